// File: rtl/dmem_store_port_pkg.sv
// rtl/dmem_store_port_pkg.sv - shared encodings and lane helpers for dmem_store_port
//
// Purpose: store size encodings, FSM state type, default FIFO depth and the
// lane formatting helpers that turn a retired store into a word write with
// byte enables.
// Ports: none (package).

package dmem_store_port_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int DEPTH_DEFAULT = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  // Byte enables for a store; the reserved size code behaves as a word.
  function automatic logic [3:0] lane_be(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: lane_be = 4'b0001 << addr_lo;
      SZ_HALF: lane_be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  // Replicate the LSB-aligned store data across every lane it could occupy,
  // so the memory only needs the byte enables to pick the right bytes.
  function automatic logic [31:0] lane_wdata(input logic [1:0]  size,
                                             input logic [31:0] data);
    case (size)
      SZ_BYTE: lane_wdata = {4{data[7:0]}};
      SZ_HALF: lane_wdata = {2{data[15:0]}};
      default: lane_wdata = data;
    endcase
  endfunction

endpackage

// File: rtl/dmem_store_port_store_fifo.sv
// rtl/dmem_store_port_store_fifo.sv - synchronous FIFO holding formatted stores
//
// Purpose: DEPTH-entry FIFO with a combinational head read. A push while full
// is accepted only when a pop happens on the same edge; a pop while empty is
// ignored.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   push, wdata      write request and entry
//   pop              remove head
//   rdata            current head entry
//   count            occupancy, 0..DEPTH
//   full, empty      occupancy flags

module dmem_store_port_store_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign rdata = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dmem_store_port.sv
// rtl/dmem_store_port.sv - retire store queue driving the data-memory write port
//
// Purpose: formats each retired store into an aligned word write with byte
// enables, queues it, and issues it to memory over a req/ack handshake.
// Optional feature macro: STORE_MISALIGN_CHK_EN (drops misaligned half/word
// stores and pulses o_misalign).
// Ports:
//   i_clk, i_rstn     clock, asynchronous active-low reset
//   i_write           store valid from retire
//   i_size            00 byte, 01 half, 10/11 word
//   i_wr_addr         byte address
//   i_data            LSB-aligned store data
//   o_full            queue full
//   o_empty           nothing queued and no request outstanding
//   o_overflow        sticky: store dropped because the queue was full
//   o_mem_req         write request, held until i_mem_ack
//   o_mem_addr        word address
//   o_mem_wdata       lane-replicated write data
//   o_mem_be          byte enables
//   i_mem_ack         memory accepts the request
//   o_misalign        (STORE_MISALIGN_CHK_EN only) misaligned store dropped

module dmem_store_port
  import dmem_store_port_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int MADDR_W = 30
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_write,
  input  logic [1:0]         i_size,
  input  logic [31:0]        i_wr_addr,
  input  logic [31:0]        i_data,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_overflow,
  output logic               o_mem_req,
  output logic [MADDR_W-1:0] o_mem_addr,
  output logic [31:0]        o_mem_wdata,
  output logic [3:0]         o_mem_be,
`ifdef STORE_MISALIGN_CHK_EN
  output logic               o_misalign,
`endif
  input  logic               i_mem_ack
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = MADDR_W + 4 + 32;

  state_t             state;
  state_t             state_nxt;
  logic               fifo_push;
  logic               fifo_pop;
  logic               req_clr;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head;
  logic [CNT_W-1:0]   fifo_cnt;
  logic               fifo_full;
  logic               fifo_empty;
  logic               misalign;
  logic               accept;

`ifdef STORE_MISALIGN_CHK_EN
  assign misalign = i_write &&
                    (((i_size == SZ_HALF) && i_wr_addr[0]) ||
                     (i_size[1] && (i_wr_addr[1:0] != 2'b00)));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) o_misalign <= 1'b0;
    else         o_misalign <= misalign;
  end
`else
  assign misalign = 1'b0;
`endif

  // A misaligned store is rejected before the full check, so it never
  // counts as an overflow.
  assign accept    = i_write && !misalign;
  assign fifo_push = accept && (!fifo_full || fifo_pop);

  assign push_entry = {i_wr_addr[MADDR_W+1:2],
                       lane_be(i_size, i_wr_addr[1:0]),
                       lane_wdata(i_size, i_data)};

  dmem_store_port_store_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rstn  (i_rstn),
    .push  (fifo_push),
    .wdata (push_entry),
    .pop   (fifo_pop),
    .rdata (head),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign o_full  = (fifo_cnt == CNT_W'(DEPTH));
  assign o_empty = (fifo_cnt == '0) && !o_mem_req;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    req_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        // The accepted request is replaced on the same edge when more work
        // is queued, giving one write per cycle at full throughput.
        if (i_mem_ack) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
          end else begin
            req_clr   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_mem_req   <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_be    <= '0;
      o_mem_wdata <= '0;
    end else if (fifo_pop) begin
      o_mem_req   <= 1'b1;
      o_mem_addr  <= head[ENTRY_W-1 -: MADDR_W];
      o_mem_be    <= head[35:32];
      o_mem_wdata <= head[31:0];
    end else if (req_clr) begin
      o_mem_req   <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_overflow <= 1'b0;
    end else if (accept && fifo_full && !fifo_pop) begin
      o_overflow <= 1'b1;
    end
  end

endmodule
